audio_mixer: RTL and testbench
==============================

// Module: audio_mixer
// PURPOSE
//   Parametrised N-channel stereo mixer replacing the fixed two-source (PSG + PCM) adder ahead of dacif.
//   On each next_sample strobe it snapshots all channel samples, applies per-channel gain and mute,
//   and accumulates one channel per clock with a shared multiplier per side.
//   It saturates the result and presents left-justified OUT_W words to dacif.
// PARAMETERS
//   NUM_CH  4   number of stereo sources (>=2)
//   IN_W    16  signed sample width per channel
//   GAIN_W  8   unsigned gain width; gain == 2**(GAIN_W-1) is unity, max just under 2.0x
//   OUT_W   24  output word width to dacif (OUT_W >= IN_W)
// PORTS
//   clk          in   1              system clock
//   rst          in   1              asynchronous, active-low reset
//   next_sample  in   1              1-cycle strobe from dacif: start a new mix
//   ch_left      in   NUM_CH*IN_W    signed left samples, channel k at [k*IN_W +: IN_W]
//   ch_right     in   NUM_CH*IN_W    signed right samples, same packing
//   ch_gain      in   NUM_CH*GAIN_W  unsigned per-channel gain, channel k at [k*GAIN_W +: GAIN_W]
//   ch_mute      in   NUM_CH         1 = channel contributes zero
//   overrun_clr  in   1              clears sticky overrun flag
//   left_data    out  OUT_W          mixed left word, left-justified, LSBs zero
//   right_data   out  OUT_W          mixed right word
//   out_valid    out  1              1-cycle pulse when left/right_data update
//   busy         out  1              high while a mix is in progress
//   overrun      out  1              sticky: next_sample arrived while busy
// BEHAVIOUR
// - Reset (rst low, async): state IDLE; left_data, right_data, out_valid, busy and overrun = 0.
//   Snapshot registers, accumulators and channel counter are cleared.
//   Reset mid-mix aborts the mix; no out_valid is produced for it.
// - FSM states: IDLE -> ACCUM -> SAT -> IDLE.
//   - IDLE: next_sample at cycle T captures ch_left/ch_right/ch_gain/ch_mute into snapshot regs.
//     Accumulators clear, ch_idx=0, busy=1 from T+1, go ACCUM.
//   - ACCUM: one channel per cycle, cycles T+1..T+NUM_CH.
//     acc += mute[ch_idx] ? 0 : sample[ch_idx]*$signed({1'b0,gain[ch_idx]}).
//     Left and right use separate multipliers and run in parallel.
//     ch_idx increments; after ch_idx==NUM_CH-1 go SAT.
//   - SAT (cycle T+NUM_CH+1): scaled = acc >>> (GAIN_W-1), arithmetic shift, truncating toward -inf.
//     Saturate scaled to IN_W signed range [-2**(IN_W-1), 2**(IN_W-1)-1].
//     left/right_data <= {sat, (OUT_W-IN_W) zeros}. out_valid=1 for this cycle only; busy=0; go IDLE.
// - Latency: strobe at T -> data and out_valid at T+NUM_CH+1. Outputs hold until the next SAT.
// - Accumulator width: IN_W+GAIN_W+1+$clog2(NUM_CH) signed; it never wraps.
// - Inputs change freely after the snapshot; only the captured values are mixed.
// - next_sample while busy (ACCUM or SAT): ignored, mix continues unchanged, overrun <= 1.
// - next_sample in IDLE on the same cycle SAT exits: not possible; SAT always returns to IDLE first.
// - overrun_clr and a new overrun event on the same cycle: set wins.
// - A full-scale sum of NUM_CH channels saturates; it never wraps.
// - All-muted channels, or all gains 0: output exactly 0.
// TESTING
// - NUM_CH=4, ch0 L=0x1000 at unity gain (128), others muted, strobe.
//   -> left_data=0x100000 at T+5 with one out_valid pulse; right_data=0.
// - All 4 channels L=0x7FFF, gain 255, strobe -> left_data=0x7FFF00 (+sat).
//   All 4 channels L=0x8000, gain 255 -> left_data=0x800000 (-sat).
// - ch0=+0x4000, ch1=-0x4000, both unity, others muted -> left_data=0x000000.
//   Change inputs at T+1 -> result unchanged.
// - ch0=-1, gain 64 (0.5x): -1*64 >>> 7 = -1 -> left_data=0xFFFF00 (floor rounding).
// - Strobe, then a second strobe at T+2 -> exactly one out_valid (T+5) and overrun=1.
//   overrun_clr -> 0; clr and new overrun on the same cycle -> stays 1.
// - Assert rst low at T+3 mid-mix -> outputs 0, no out_valid.
//   Release and strobe -> normal result at T'+5.

Source files
------------

// File: rtl/audio_mixer.sv
// N-channel stereo mixer: snapshots all channels on next_sample, accumulates one
// gained channel per clock per side, then saturates and left-justifies for dacif.
module audio_mixer #(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int GAIN_W = 8,
  parameter int OUT_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     next_sample,
  input  logic [NUM_CH*IN_W-1:0]   ch_left,
  input  logic [NUM_CH*IN_W-1:0]   ch_right,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]        ch_mute,
  input  logic                     overrun_clr,
  output logic [OUT_W-1:0]         left_data,
  output logic [OUT_W-1:0]         right_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(NUM_CH);
  localparam int PRD_W = IN_W + GAIN_W + 1;
  localparam int ACC_W = PRD_W + CNT_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SAT   = 2'd2;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-IN_W+1){1'b0}}, {(IN_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-IN_W+1){1'b1}}, {(IN_W-1){1'b0}}};

  logic [1:0]                state_q, state_d;
  logic [NUM_CH*IN_W-1:0]    snap_l_q, snap_l_d;
  logic [NUM_CH*IN_W-1:0]    snap_r_q, snap_r_d;
  logic [NUM_CH*GAIN_W-1:0]  snap_g_q, snap_g_d;
  logic [NUM_CH-1:0]         snap_m_q, snap_m_d;
  logic signed [ACC_W-1:0]   acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0]   acc_r_q, acc_r_d;
  logic [CNT_W-1:0]          ch_idx_q, ch_idx_d;
  logic [OUT_W-1:0]          left_q, left_d;
  logic [OUT_W-1:0]          right_q, right_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

  logic signed [IN_W-1:0]    samp_l, samp_r;
  logic signed [GAIN_W:0]    gain_s;
  logic signed [PRD_W-1:0]   prod_l, prod_r;
  logic signed [ACC_W-1:0]   sum_l, sum_r;

  // Scale back by unity gain (floor), clamp to the IN_W signed range, left-justify.
  function automatic logic [OUT_W-1:0] sat_justify(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] scaled;
    logic [IN_W-1:0]         s;
    logic [OUT_W-1:0]        w;
    scaled = acc >>> (GAIN_W - 1);
    if (scaled > SAT_MAX)      s = {1'b0, {(IN_W-1){1'b1}}};
    else if (scaled < SAT_MIN) s = {1'b1, {(IN_W-1){1'b0}}};
    else                       s = scaled[IN_W-1:0];
    w = '0;
    w[OUT_W-1 -: IN_W] = s;
    return w;
  endfunction

  always_comb begin
    samp_l = snap_l_q[ch_idx_q*IN_W +: IN_W];
    samp_r = snap_r_q[ch_idx_q*IN_W +: IN_W];
    gain_s = $signed({1'b0, snap_g_q[ch_idx_q*GAIN_W +: GAIN_W]});
    prod_l = samp_l * gain_s;
    prod_r = samp_r * gain_s;
    if (snap_m_q[ch_idx_q]) begin
      prod_l = '0;
      prod_r = '0;
    end
    sum_l = acc_l_q + {{CNT_W{prod_l[PRD_W-1]}}, prod_l};
    sum_r = acc_r_q + {{CNT_W{prod_r[PRD_W-1]}}, prod_r};
  end

  always_comb begin
    state_d  = state_q;
    snap_l_d = snap_l_q;
    snap_r_d = snap_r_q;
    snap_g_d = snap_g_q;
    snap_m_d = snap_m_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    ch_idx_d = ch_idx_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (next_sample) begin
          snap_l_d = ch_left;
          snap_r_d = ch_right;
          snap_g_d = ch_gain;
          snap_m_d = ch_mute;
          acc_l_d  = '0;
          acc_r_d  = '0;
          ch_idx_d = '0;
          busy_d   = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_l_d  = sum_l;
        acc_r_d  = sum_r;
        ch_idx_d = ch_idx_q + CNT_W'(1);
        // Register the saturated words on the last channel so they are visible during SAT.
        if (ch_idx_q == CNT_W'(NUM_CH - 1)) begin
          left_d  = sat_justify(sum_l);
          right_d = sat_justify(sum_r);
          valid_d = 1'b1;
          state_d = SAT;
        end
      end
      SAT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Set dominates clear when both happen in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (next_sample && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      snap_l_q  <= '0;
      snap_r_q  <= '0;
      snap_g_q  <= '0;
      snap_m_q  <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      ch_idx_q  <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_l_q  <= snap_l_d;
      snap_r_q  <= snap_r_d;
      snap_g_q  <= snap_g_d;
      snap_m_q  <= snap_m_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      ch_idx_q  <= ch_idx_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign left_data  = left_q;
  assign right_data = right_q;
  assign out_valid  = valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer (4 channels, 16-bit samples, 8-bit gain, 24-bit output).
module tb_audio_mixer;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int GAIN_W = 8;
  localparam int OUT_W  = 24;

  logic        clk;
  logic        rst;
  logic        next_sample;
  logic [63:0] ch_left;
  logic [63:0] ch_right;
  logic [31:0] ch_gain;
  logic [3:0]  ch_mute;
  logic        overrun_clr;
  logic [23:0] left_data;
  logic [23:0] right_data;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];

  audio_mixer #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .next_sample(next_sample),
    .ch_left(ch_left), .ch_right(ch_right), .ch_gain(ch_gain), .ch_mute(ch_mute),
    .overrun_clr(overrun_clr),
    .left_data(left_data), .right_data(right_data),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [23:0] model_side(input logic [63:0] s, input logic [31:0] g,
                                             input logic [3:0] m);
    longint acc;
    longint sc;
    logic [15:0] r;
    acc = 0;
    for (int k = 0; k < 4; k++)
      if (!m[k]) acc += longint'($signed(s[k*16 +: 16])) * longint'(g[k*8 +: 8]);
    sc = acc >>> 7;
    if (sc > 32767)       r = 16'h7FFF;
    else if (sc < -32768) r = 16'h8000;
    else                  r = sc[15:0];
    return {r, 8'h00};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      logic [47:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid: got L=%h R=%h, no mix pending", left_data, right_data);
      end else begin
        e = exp_q.pop_front();
        if ({left_data, right_data} !== e) begin
          errors++;
          $display("FAIL mix_result: got L=%h R=%h, expected L=%h R=%h",
                   left_data, right_data, e[47:24], e[23:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int k, input logic [15:0] l, input logic [15:0] r,
                        input logic [7:0] g, input logic m);
    ch_left[k*16 +: 16]  = l;
    ch_right[k*16 +: 16] = r;
    ch_gain[k*8 +: 8]    = g;
    ch_mute[k]           = m;
  endtask

  task automatic clear_ch();
    ch_left = '0; ch_right = '0; ch_gain = '0; ch_mute = '1;
  endtask

  // Strobe for one cycle; returns during cycle T+1.
  task automatic start_mix(input logic expect_out);
    @(posedge clk); #1;
    if (expect_out)
      exp_q.push_back({model_side(ch_left, ch_gain, ch_mute), model_side(ch_right, ch_gain, ch_mute)});
    next_sample = 1'b1;
    @(posedge clk); #1;
    next_sample = 1'b0;
  endtask

  // Cycles after T until out_valid is seen; -1 if it never arrives.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({left_data, right_data, out_valid, busy, overrun} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: got L=%h R=%h v=%b b=%b o=%b, expected all 0",
               left_data, right_data, out_valid, busy, overrun);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unity();
    int n;
    clear_ch();
    set_ch(0, 16'h1000, 16'h0000, 8'd128, 1'b0);
    set_ch(1, 16'h2222, 16'h3333, 8'd200, 1'b1);
    set_ch(2, 16'h7000, 16'h9000, 8'd255, 1'b1);
    start_mix(1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL unity_busy: got %b, expected 1", busy); end
    wait_valid(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL unity_latency: got %0d, expected 5", n); end
    checks++;
    if (left_data !== 24'h100000 || right_data !== 24'h000000) begin
      errors++;
      $display("FAIL unity_value: got L=%h R=%h, expected L=100000 R=000000", left_data, right_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || left_data !== 24'h100000) begin
      errors++;
      $display("FAIL unity_after: got v=%b b=%b L=%h, expected v=0 b=0 L=100000",
               out_valid, busy, left_data);
    end
  endtask

  task automatic test_saturation();
    int n;
    for (int k = 0; k < 4; k++) set_ch(k, 16'h7FFF, 16'h8000, 8'd255, 1'b0);
    start_mix(1'b1);
    wait_valid(n);
    checks++;
    if (left_data !== 24'h7FFF00 || right_data !== 24'h800000) begin
      errors++;
      $display("FAIL sat_value: got L=%h R=%h, expected L=7fff00 R=800000", left_data, right_data);
    end
    for (int k = 0; k < 4; k++) set_ch(k, 16'h8000, 16'h7FFF, 8'd255, 1'b0);
    start_mix(1'b1);
    wait_valid(n);
    checks++;
    if (left_data !== 24'h800000 || right_data !== 24'h7FFF00) begin
      errors++;
      $display("FAIL sat_swap: got L=%h R=%h, expected L=800000 R=7fff00", left_data, right_data);
    end
  endtask

  task automatic test_cancel_snapshot();
    int n;
    clear_ch();
    set_ch(0, 16'h4000, 16'h1234, 8'd128, 1'b0);
    set_ch(1, 16'hC000, 16'h0100, 8'd128, 1'b0);
    start_mix(1'b1);
    for (int k = 0; k < 4; k++)
      set_ch(k, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 8'd255, 1'b0);
    wait_valid(n);
    checks++;
    if (left_data !== 24'h000000 || right_data !== 24'h133400) begin
      errors++;
      $display("FAIL cancel_snapshot: got L=%h R=%h, expected L=000000 R=133400", left_data, right_data);
    end
  endtask

  task automatic test_floor_and_zero();
    int n;
    clear_ch();
    set_ch(0, 16'hFFFF, 16'h0001, 8'd64, 1'b0);
    start_mix(1'b1);
    wait_valid(n);
    checks++;
    if (left_data !== 24'hFFFF00 || right_data !== 24'h000000) begin
      errors++;
      $display("FAIL floor_round: got L=%h R=%h, expected L=ffff00 R=000000", left_data, right_data);
    end
    for (int k = 0; k < 4; k++) set_ch(k, 16'h7FFF, 16'h8000, 8'd255, 1'b1);
    start_mix(1'b1);
    wait_valid(n);
    checks++;
    if (left_data !== 24'h0 || right_data !== 24'h0) begin
      errors++;
      $display("FAIL all_muted: got L=%h R=%h, expected 0 0", left_data, right_data);
    end
    for (int k = 0; k < 4; k++) set_ch(k, 16'h7FFF, 16'h8000, 8'd0, 1'b0);
    start_mix(1'b1);
    wait_valid(n);
    checks++;
    if (left_data !== 24'h0 || right_data !== 24'h0) begin
      errors++;
      $display("FAIL all_gain0: got L=%h R=%h, expected 0 0", left_data, right_data);
    end
  endtask

  task automatic test_overrun();
    int pulses;
    clear_ch();
    set_ch(2, 16'h0800, 16'hF800, 8'd160, 1'b0);
    start_mix(1'b1);
    @(posedge clk); #1 next_sample = 1'b1;
    @(posedge clk); #1 next_sample = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d, expected 1", pulses); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b, expected 1", overrun); end
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b, expected 0", overrun); end
    start_mix(1'b1);
    @(posedge clk); #1 next_sample = 1'b1; overrun_clr = 1'b1;
    @(posedge clk); #1 next_sample = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins: got %b, expected 1", overrun); end
    repeat (8) @(negedge clk);
    @(posedge clk); #1 overrun_clr = 1'b1;
    @(posedge clk); #1 overrun_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++)
        set_ch(k, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0));
      start_mix(1'b1);
      wait_valid(n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d, expected 5", r, n); end
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun: got %b, expected 0", overrun); end
  endtask

  task automatic test_reset_mid_mix();
    int n;
    int pulses;
    clear_ch();
    set_ch(1, 16'h3000, 16'hD000, 8'd128, 1'b0);
    start_mix(1'b0);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({left_data, right_data, out_valid, busy, overrun} !== 51'd0) begin
      errors++;
      $display("FAIL midmix_reset: got L=%h R=%h v=%b b=%b o=%b, expected all 0",
               left_data, right_data, out_valid, busy, overrun);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL midmix_no_valid: got %0d, expected 0", pulses); end
    start_mix(1'b1);
    wait_valid(n);
    checks++;
    if (n !== 5 || left_data !== 24'h300000 || right_data !== 24'hD00000) begin
      errors++;
      $display("FAIL post_reset_mix: got n=%0d L=%h R=%h, expected n=5 L=300000 R=d00000",
               n, left_data, right_data);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++)
        set_ch(k, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 4) == 0));
      start_mix(1'b1);
      wait_valid(n);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL random_latency[%0d]: got %0d, expected 5", r, n); end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    next_sample = 1'b0;
    overrun_clr = 1'b0;
    ch_left = '0; ch_right = '0; ch_gain = '0; ch_mute = '0;
    test_reset();
    test_unity();
    test_saturation();
    test_cancel_snapshot();
    test_floor_and_zero();
    test_overrun();
    test_back_to_back();
    test_reset_mid_mix();
    test_random();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
